n64_poll_sequencer: RTL and testbench
=====================================

# n64_poll_sequencer

Sequences periodic N64 controller status polls in the `clk_4M` domain. Each poll runs as one transaction:
- trigger the command transmitter with the poll command;
- hand the single-wire bus to the receiver;
- wait for the 32-bit controller response or a timeout;
- latch the result for the rest of the design.

The block sits between the system logic and the N64 command TX / `n64_readcmd_rx` pair and owns the bus direction.

## Interface
Parameters:
- `POLL_PERIOD`, 66667 — idle cycles between transactions (about 16.7 ms at 4 MHz); minimum 1
- `TURN_CYCLES`, 8 — guard cycles between TX completion and RX enable; minimum 1
- `RX_TIMEOUT`, 200 — RECV cycles allowed before declaring timeout; covers 33 bits × 4 samples plus margin
- `POLL_CMD`, 8'h01 — command byte presented to the TX

Ports:
- `clk_4M` in 1 — 4 MHz sample clock
- `rst_n` in 1 — asynchronous, active-low reset
- `en` in 1 — allows new transactions to start
- `poll_now` in 1 — one-cycle request to skip the remaining idle wait
- `tx_start` out 1 — one-cycle start pulse to the TX
- `tx_cmd` out 8 — command byte, constant `POLL_CMD`
- `tx_busy` in 1 — TX is transmitting (command plus stop bit)
- `bus_oe` out 1 — 1 = TX drives the line, 0 = line released to the controller
- `rx_enable` out 1 — enable for `n64_readcmd_rx`
- `rx_data` in 32 — receiver `ctrl_state`
- `rx_done` in 1 — receiver `ctrl_clk`, one-cycle pulse when a word is complete
- `ctrl_state` out 32 — last valid controller word
- `state_valid` out 1 — one-cycle pulse when `ctrl_state` updates
- `timeout_err` out 1 — one-cycle pulse on a failed transaction
- `busy` out 1 — high in every state except IDLE

## Operation
States: IDLE, START, SEND, TURN, RECV, DONE.

- **IDLE**
  - Idle counter increments each cycle while `en`=1; it holds while `en`=0.
  - Go to START when the counter reaches `POLL_PERIOD`-1, or when `poll_now`=1 and `en`=1.
  - The counter clears on exit.
- **START**
  - `tx_start`=1 and `bus_oe`=1 for exactly this one cycle.
  - Next state: SEND.
- **SEND**
  - `bus_oe`=1.
  - Wait for `tx_busy` to rise, then fall; then go to TURN.
  - If `tx_busy` has not risen within 4 cycles of entering SEND: pulse `timeout_err` and go to IDLE.
- **TURN**
  - `bus_oe`=0, `rx_enable`=0.
  - Hold `TURN_CYCLES` cycles, then go to RECV.
- **RECV**
  - `rx_enable`=1; timeout counter increments each cycle.
  - On `rx_done`=1: capture `rx_data` into `ctrl_state` and go to DONE.
  - On count = `RX_TIMEOUT`-1 with no `rx_done`: pulse `timeout_err` and go to IDLE. `ctrl_state` is unchanged.
  - If `rx_done` and the timeout coincide, `rx_done` wins (valid capture).
- **DONE**
  - `state_valid`=1 for one cycle, `rx_enable`=0.
  - Next state: IDLE.

Other rules:
- `en` deasserted mid-transaction does not abort; the transaction completes, then the block holds in IDLE.
- `poll_now` outside IDLE is ignored; it is not queued.
- `rx_done` outside RECV is ignored.
- `bus_oe`=0 in every state except START and SEND.

## Timing
- Reset values: state IDLE, all counters 0, `ctrl_state`=0, and all other outputs 0.
  - Exception: `tx_cmd` = `POLL_CMD`.
- Reset takes effect immediately, including mid-transaction. `bus_oe` drops to 0 asynchronously.
- First automatic `tx_start` occurs `POLL_PERIOD` cycles after `rst_n` release with `en`=1.
- `poll_now` in IDLE gives `tx_start` on the next cycle.
- `tx_busy` fall to `rx_enable` rise is `TURN_CYCLES`+1 cycles.
- `rx_done` to `ctrl_state` update is 1 cycle.
- `state_valid` pulses in the same cycle `ctrl_state` shows the new value.
- Automatic poll spacing = `POLL_PERIOD` + transaction length + 1. The idle wait restarts after each transaction.
- All outputs are registered.

## Configuration
- `N64_POLL_ERRCNT_EN` defined:
  - Adds output `err_count` out 8: a saturating count of `timeout_err` pulses.
  - It holds at 255 once reached.
  - It resets to 0 on `rst_n` and on every `state_valid`.
- Macro undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
Bench parameters: `POLL_PERIOD`=100, `TURN_CYCLES`=8, `RX_TIMEOUT`=200. The TX model asserts `tx_busy` for 36 cycles, starting the cycle after `tx_start`.

1. Reset release with `en`=1 -> `tx_start` at cycle 100, `bus_oe` low 1 cycle after `tx_busy` falls, `rx_enable` 9 cycles after `tx_busy` falls.
2. Receiver model returns 32'hA5C3_0F81 with `rx_done` 132 cycles into RECV -> `ctrl_state`=32'hA5C3_0F81 with a single `state_valid` pulse; next `tx_start` 100 idle cycles later.
3. No `rx_done` -> `timeout_err` pulse after 200 RECV cycles, `ctrl_state` retains the previous value, and `err_count` increments (macro on).
4. `tx_busy` held low -> `timeout_err` 4 cycles after entering SEND, then IDLE; `rx_enable` never asserts.
5. `poll_now` at idle cycle 10, then `en`=0 asserted in RECV -> immediate transaction completes with `state_valid`, and no further `tx_start` while `en`=0.
6. `rst_n` asserted during RECV -> `rx_enable`, `bus_oe` and `busy` drop immediately; `ctrl_state`=0; next `tx_start` 100 cycles after release.

Source files
------------

// File: rtl/n64_poll_sequencer.sv
// -----------------------------------------------------------------------------
// n64_poll_sequencer
//
// Runs periodic N64 controller status polls in the 4 MHz sample-clock domain.
// Each poll is one transaction:
//   IDLE -> START (pulse tx_start) -> SEND (wait for tx_busy rise then fall)
//        -> TURN (guard time with the line released) -> RECV (wait for the
//        32-bit response or a timeout) -> DONE (pulse state_valid) -> IDLE.
// The block owns the bus direction: bus_oe is high only in START and SEND.
//
// Ports:
//   clk_4M       in   4 MHz sample clock
//   rst_n        in   asynchronous active-low reset
//   en           in   allows new transactions to start
//   poll_now     in   one-cycle request to skip the remaining idle wait
//   tx_start     out  one-cycle start pulse to the command transmitter
//   tx_cmd       out  command byte, constant POLL_CMD
//   tx_busy      in   transmitter is sending (command plus stop bit)
//   bus_oe       out  1 = TX drives the line, 0 = line released
//   rx_enable    out  enable for the response receiver
//   rx_data      in   receiver word
//   rx_done      in   receiver word-complete pulse
//   ctrl_state   out  last valid controller word
//   state_valid  out  one-cycle pulse when ctrl_state updates
//   timeout_err  out  one-cycle pulse on a failed transaction
//   busy         out  high in every state except IDLE
//   err_count    out  (N64_POLL_ERRCNT_EN only) saturating timeout count,
//                     cleared on every state_valid
//
// Optional feature macro: N64_POLL_ERRCNT_EN
// -----------------------------------------------------------------------------
module n64_poll_sequencer #(
  parameter int         POLL_PERIOD = 66667,
  parameter int         TURN_CYCLES = 8,
  parameter int         RX_TIMEOUT  = 200,
  parameter logic [7:0] POLL_CMD    = 8'h01
) (
  input  logic        clk_4M,
  input  logic        rst_n,
  input  logic        en,
  input  logic        poll_now,
  output logic        tx_start,
  output logic [7:0]  tx_cmd,
  input  logic        tx_busy,
  output logic        bus_oe,
  output logic        rx_enable,
  input  logic [31:0] rx_data,
  input  logic        rx_done,
  output logic [31:0] ctrl_state,
  output logic        state_valid,
  output logic        timeout_err,
  output logic        busy
`ifdef N64_POLL_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  // Cycles allowed in SEND for tx_busy to rise.
  localparam int SEND_WAIT = 4;

  // One shared counter serves every state; it is cleared on each state exit.
  localparam int MAX_A   = (POLL_PERIOD > TURN_CYCLES) ? POLL_PERIOD : TURN_CYCLES;
  localparam int MAX_B   = (RX_TIMEOUT > SEND_WAIT) ? RX_TIMEOUT : SEND_WAIT;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(SEND_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_TURN,
    S_RECV,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              seen_q, seen_d;       // tx_busy has risen in this SEND
  logic              tx_start_q, tx_start_d;
  logic              bus_oe_q, bus_oe_d;
  logic              rx_enable_q, rx_enable_d;
  logic              busy_q, busy_d;
  logic              state_valid_q, state_valid_d;
  logic              timeout_err_q, timeout_err_d;
  logic [31:0]       ctrl_state_q, ctrl_state_d;
  logic              capture;
  logic              timeout_hit;

  // Next-state and counter logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_d      = seen_q;
    capture     = 1'b0;
    timeout_hit = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Counter holds while en is low; poll_now only counts when enabled.
        if (en) begin
          if (poll_now || (cnt_q == IDLE_LAST)) begin
            state_d = S_START;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_START: begin
        state_d = S_SEND;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end

      S_SEND: begin
        seen_d = seen_q | tx_busy;
        if (seen_q && !tx_busy) begin
          state_d = S_TURN;
          cnt_d   = '0;
        end else if (!seen_q && !tx_busy && (cnt_q == SEND_LAST)) begin
          // Transmitter never acknowledged the start pulse.
          state_d     = S_IDLE;
          cnt_d       = '0;
          timeout_hit = 1'b1;
        end else if (!seen_d) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = S_RECV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RECV: begin
        // rx_done is checked first so a word arriving on the last
        // allowed cycle is still accepted.
        if (rx_done) begin
          state_d = S_DONE;
          cnt_d   = '0;
          capture = 1'b1;
        end else if (cnt_q == RECV_LAST) begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end
    endcase

    // Outputs are decoded from the next state so that the registered
    // copies line up with the state register.
    tx_start_d    = (state_d == S_START);
    bus_oe_d      = (state_d == S_START) || (state_d == S_SEND);
    rx_enable_d   = (state_d == S_RECV);
    busy_d        = (state_d != S_IDLE);
    state_valid_d = capture;
    timeout_err_d = timeout_hit;
    ctrl_state_d  = capture ? rx_data : ctrl_state_q;
  end

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      seen_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      bus_oe_q      <= 1'b0;
      rx_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      state_valid_q <= 1'b0;
      timeout_err_q <= 1'b0;
      ctrl_state_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      seen_q        <= seen_d;
      tx_start_q    <= tx_start_d;
      bus_oe_q      <= bus_oe_d;
      rx_enable_q   <= rx_enable_d;
      busy_q        <= busy_d;
      state_valid_q <= state_valid_d;
      timeout_err_q <= timeout_err_d;
      ctrl_state_q  <= ctrl_state_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_cmd      = POLL_CMD;
  assign bus_oe      = bus_oe_q;
  assign rx_enable   = rx_enable_q;
  assign busy        = busy_q;
  assign state_valid = state_valid_q;
  assign timeout_err = timeout_err_q;
  assign ctrl_state  = ctrl_state_q;

`ifdef N64_POLL_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Saturating count of failed transactions since the last good word.
  always_comb begin
    err_count_d = err_count_q;
    if (state_valid_d) begin
      err_count_d = '0;
    end else if (timeout_err_d && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_n64_poll_sequencer.sv
// -----------------------------------------------------------------------------
// tb_n64_poll_sequencer
//
// Scoreboard bench for n64_poll_sequencer (POLL_PERIOD=100, TURN_CYCLES=8,
// RX_TIMEOUT=200). The stimulus process pushes hand-computed expected events
// (kind, cycle number since reset release, data) into a queue; a monitor pops
// and compares whenever the DUT shows tx_start, a bus_oe fall, an rx_enable
// rise, state_valid or timeout_err. TX model: tx_busy high for 36 cycles
// starting the cycle after tx_start. RX model: rx_done 132 cycles into RECV.
// -----------------------------------------------------------------------------
module tb_n64_poll_sequencer;

  localparam int EV_TXS = 0;
  localparam int EV_OEF = 1;
  localparam int EV_RXE = 2;
  localparam int EV_SV  = 3;
  localparam int EV_TO  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        poll_now;
  logic        tx_busy;
  logic        rx_done;
  logic [31:0] rx_data;
  logic        tx_start;
  logic [7:0]  tx_cmd;
  logic        bus_oe;
  logic        rx_enable;
  logic [31:0] ctrl_state;
  logic        state_valid;
  logic        timeout_err;
  logic        busy;
`ifdef N64_POLL_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  always #5 clk = ~clk;

  n64_poll_sequencer #(
    .POLL_PERIOD (100),
    .TURN_CYCLES (8),
    .RX_TIMEOUT  (200),
    .POLL_CMD    (8'h01)
  ) dut (
    .clk_4M      (clk),
    .rst_n       (rst_n),
    .en          (en),
    .poll_now    (poll_now),
    .tx_start    (tx_start),
    .tx_cmd      (tx_cmd),
    .tx_busy     (tx_busy),
    .bus_oe      (bus_oe),
    .rx_enable   (rx_enable),
    .rx_data     (rx_data),
    .rx_done     (rx_done),
    .ctrl_state  (ctrl_state),
    .state_valid (state_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
`ifdef N64_POLL_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  // Cycle index: after the k-th rising edge following reset release, cyc==k.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
    logic [7:0]  errc;
  } ev_t;

  ev_t   exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    tx_mode;            // 1 = TX model answers tx_start, 0 = silent
  int    rx_mode;            // 1 = RX model returns rx_word, 0 = silent
  logic [31:0] rx_word;
  string ev_name [5] = '{"tx_start", "bus_oe_fall", "rx_enable_rise", "state_valid", "timeout_err"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int c, input logic [31:0] data, input logic [7:0] errc);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = data;
    e.errc = errc;
    exp_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic handle(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got %s at cyc %0d required no event", ev_name[kind], cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_cycle", 32'(cyc), 32'(e.cyc));
      case (kind)
        EV_TXS: begin
          check("tx_cmd", {24'd0, tx_cmd}, 32'h01);
          check("bus_oe_in_start", {31'd0, bus_oe}, 32'd1);
          check("busy_in_start", {31'd0, busy}, 32'd1);
        end
        EV_RXE: check("bus_oe_in_recv", {31'd0, bus_oe}, 32'd0);
        EV_SV, EV_TO: begin
          check("ctrl_state", ctrl_state, e.data);
`ifdef N64_POLL_ERRCNT_EN
          check("err_count", {24'd0, err_count}, {24'd0, e.errc});
`endif
        end
        default: ;
      endcase
      $display("event %s cyc=%0d ctrl_state=0x%08h", ev_name[kind], cyc, ctrl_state);
    end
  endtask

  // Monitor: samples on the falling edge, pops one expectation per event.
  initial begin
    logic prev_oe;
    logic prev_rxe;
    prev_oe  = 1'b0;
    prev_rxe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (tx_start)               handle(EV_TXS);
        if (prev_oe && !bus_oe)     handle(EV_OEF);
        if (!prev_rxe && rx_enable) handle(EV_RXE);
        if (state_valid)            handle(EV_SV);
        if (timeout_err)            handle(EV_TO);
      end
      prev_oe  = bus_oe;
      prev_rxe = rx_enable;
    end
  end

  // TX model: tx_busy high for 36 cycles starting the cycle after tx_start.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && (tx_mode != 0)) begin
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (36) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // RX model: rx_done seen by the DUT on the 132nd RECV clock edge.
  initial begin
    logic prev;
    rx_done = 1'b0;
    rx_data = '0;
    prev    = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_enable && !prev && (rx_mode != 0)) begin
        repeat (131) @(negedge clk);
        rx_data = rx_word;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
      end
      prev = rx_enable;
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_tx_start"},    {31'd0, tx_start},    32'd0);
    check({tag, "_bus_oe"},      {31'd0, bus_oe},      32'd0);
    check({tag, "_rx_enable"},   {31'd0, rx_enable},   32'd0);
    check({tag, "_busy"},        {31'd0, busy},        32'd0);
    check({tag, "_state_valid"}, {31'd0, state_valid}, 32'd0);
    check({tag, "_timeout_err"}, {31'd0, timeout_err}, 32'd0);
    check({tag, "_ctrl_state"},  ctrl_state,           32'd0);
    check({tag, "_tx_cmd"},      {24'd0, tx_cmd},      32'h01);
`ifdef N64_POLL_ERRCNT_EN
    check({tag, "_err_count"},   {24'd0, err_count},   32'd0);
`endif
  endtask

  // Stimulus
  initial begin
    rst_n    = 1'b0;
    en       = 1'b1;
    poll_now = 1'b0;
    tx_mode  = 1;
    rx_mode  = 1;
    rx_word  = 32'hA5C3_0F81;
    repeat (3) @(negedge clk);
    check_reset_values("reset");

    // Poll 1: automatic start, good response.
    expect_ev(EV_TXS, 100, '0, 8'd0);
    expect_ev(EV_OEF, 138, '0, 8'd0);
    expect_ev(EV_RXE, 146, '0, 8'd0);
    expect_ev(EV_SV,  278, 32'hA5C3_0F81, 8'd0);
    // Poll 2: 100 idle cycles after DONE; receiver silent -> RECV timeout.
    expect_ev(EV_TXS, 379, '0, 8'd0);
    expect_ev(EV_OEF, 417, '0, 8'd0);
    expect_ev(EV_RXE, 425, '0, 8'd0);
    expect_ev(EV_TO,  625, 32'hA5C3_0F81, 8'd1);
    // Poll 3: transmitter silent -> SEND timeout, no RECV.
    expect_ev(EV_TXS, 725, '0, 8'd0);
    expect_ev(EV_OEF, 730, '0, 8'd0);
    expect_ev(EV_TO,  730, 32'hA5C3_0F81, 8'd2);
    // Poll 4: poll_now at idle cycle 10, en dropped during RECV.
    expect_ev(EV_TXS, 741, '0, 8'd0);
    expect_ev(EV_OEF, 779, '0, 8'd0);
    expect_ev(EV_RXE, 787, '0, 8'd0);
    expect_ev(EV_SV,  919, 32'h1234_5678, 8'd0);

    rst_n = 1'b1;

    wait_cyc(300);
    rx_mode = 0;
    wait_cyc(400);
    tx_mode = 0;
    wait_cyc(735);
    tx_mode = 1;
    rx_mode = 1;
    rx_word = 32'h1234_5678;
    wait_cyc(740);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_cyc(800);
    check("in_recv_when_en_drops", {31'd0, rx_enable}, 32'd1);
    en = 1'b0;

    // With en low: poll_now ignored, no automatic start.
    wait_cyc(950);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    wait_cyc(960);
    poll_now = 1'b1;
    @(negedge clk);
    poll_now = 1'b0;
    wait_cyc(1000);
    rx_mode = 0;
    check("ctrl_state_held", ctrl_state, 32'h1234_5678);
    check("pending_after_en_low", 32'(exp_q.size()), 32'd0);

    // Re-enable: counter was held at 0, so start 100 cycles later.
    wait_cyc(1220);
    en = 1'b1;
    expect_ev(EV_TXS, 1320, '0, 8'd0);
    expect_ev(EV_OEF, 1358, '0, 8'd0);
    expect_ev(EV_RXE, 1366, '0, 8'd0);

    // Reset in the middle of RECV.
    wait_cyc(1400);
    check("in_recv_before_reset", {31'd0, rx_enable}, 32'd1);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    check("pending_at_reset", 32'(exp_q.size()), 32'd0);
    tx_mode = 0;
    repeat (2) @(negedge clk);
    expect_ev(EV_TXS, 100, '0, 8'd0);
    expect_ev(EV_OEF, 105, '0, 8'd0);
    expect_ev(EV_TO,  105, 32'd0, 8'd1);
    rst_n = 1'b1;

    wait_cyc(120);
    check("pending_at_end", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

endmodule
